fifo_uart_tx: RTL and testbench

//  Drain side of the 32x8 byte FIFO: pops bytes via the FIFO rd/empty/rd_data interface and serializes them
//  as async UART frames (start, 8 data LSB-first, [parity], stop) on txd. Sits between the FIFO and the pad.

---
 rtl/fifo_uart_tx_pkg.sv | 22 ++
 rtl/fifo_uart_tx_if.sv | 34 +++
 rtl/fifo_uart_tx_baud.sv | 27 ++
 rtl/fifo_uart_tx.sv | 124 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// The PARITY state is only reachable when FIFO_UART_TX_PARITY_EN is defined.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   UART_DATA_W     = 8;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the byte FIFO, the UART transmitter and the pad.
// The slave modport is the transmitter's view; master is the FIFO/pad side.
interface fifo_uart_tx_if;
  import fifo_uart_tx_pkg::*;

  logic                   tx_en;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_rd;
  logic                   txd;
  logic                   busy;
  logic                   byte_done;

  modport master (
    output tx_en,
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd,
    input  txd,
    input  busy,
    input  byte_done
  );

  modport slave (
    input  tx_en,
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd,
    output txd,
    output busy,
    output byte_done
  );

endinterface

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Holding clear keeps the count at zero so every bit starts on a fresh period.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (rst || clear || (count == LAST_COUNT)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign bit_end = (count == LAST_COUNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the registered-read FIFO and sends them as UART frames on txd.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic clock,
  input  logic rst,
  fifo_uart_tx_if.slave bus
);

  localparam logic LAST_STOP = (STOP_BITS == 2);

  tx_state_t              state;
  logic [UART_DATA_W-1:0] shift_reg;
  logic [2:0]             bit_idx;
  logic                   stop_idx;
  logic                   txd_reg;
  logic                   bit_end;
  logic                   baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                   parity_bit;
`endif

  // The baud counter idles at zero until START so the start bit gets a full period.
  assign baud_clear = (state == IDLE) || (state == WAIT);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .rst    (rst),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  // The pop must be combinational so rd_data is valid during the WAIT cycle.
  assign bus.fifo_rd   = !rst && (state == IDLE) && bus.tx_en && !bus.fifo_empty;
  assign bus.txd       = txd_reg;
  assign bus.busy      = (state != IDLE);
  assign bus.byte_done = (state == STOP) && bit_end && (stop_idx == LAST_STOP);

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      txd_reg    <= UART_IDLE_LEVEL;
      shift_reg  <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          txd_reg <= UART_IDLE_LEVEL;
          if (bus.fifo_rd) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          shift_reg  <= bus.fifo_rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_bit <= even_parity(bus.fifo_rd_data);
`endif
          bit_idx    <= '0;
          stop_idx   <= 1'b0;
          txd_reg    <= 1'b0;
          state      <= START;
        end
        START: begin
          if (bit_end) begin
            txd_reg   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= DATA;
          end
        end
        // The shift register is consumed LSB first, so parity is captured up front.
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              txd_reg <= parity_bit;
              state   <= PARITY;
`else
              txd_reg <= UART_IDLE_LEVEL;
              state   <= STOP;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              txd_reg   <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            txd_reg <= UART_IDLE_LEVEL;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          txd_reg <= UART_IDLE_LEVEL;
          if (bit_end) begin
            if (stop_idx == LAST_STOP) begin
              state <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          txd_reg <= UART_IDLE_LEVEL;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: a bench-side FIFO feeds the DUT while a line-level model predicts txd sample by sample.
// Build with FIFO_UART_TX_PARITY_EN to exercise parity with two stop bits.
module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::*;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int STOPS  = 2;
  localparam int PAR    = 1;
`else
  localparam int STOPS  = 1;
  localparam int PAR    = 0;
`endif
  localparam int FRAME_BITS = 10 + PAR + (STOPS - 1);
  localparam int FRAME      = FRAME_BITS * CPB;

  logic clock = 1'b0;
  logic rst;

  fifo_uart_tx_if bus();

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (STOPS)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] fifo_q[$];
  logic [7:0] model_q[$];
  logic       exp_line[$];
  logic       exp_txd, exp_rd, exp_busy, exp_done;
  logic       txd_log[4096];
  logic       done_log[4096];
  int         checks = 0;
  int         errors = 0;
  int         pop_total = 0;

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    model_q.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask

  // One clock: the FIFO honours the pop seen before the edge and presents data after it.
  task automatic tick();
    logic rd;
    rd = bus.fifo_rd;
    @(posedge clock);
    #1;
    if (rd && fifo_q.size() > 0) begin
      bus.fifo_rd_data = fifo_q.pop_front();
      pop_total++;
    end
    bus.fifo_empty = (fifo_q.size() == 0);
    @(negedge clock);
  endtask

  task automatic push_bit(input logic v);
    for (int i = 0; i < CPB; i++) exp_line.push_back(v);
  endtask

  // Expected line: one high WAIT sample, then start, data LSB first, optional parity, stop bits.
  task automatic build_frame(input logic [7:0] b);
    exp_line.push_back(1'b1);
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) push_bit(b[i]);
    if (PAR != 0) push_bit(^b);
    for (int s = 0; s < STOPS; s++) push_bit(1'b1);
  endtask

  task automatic model_step();
    if (rst) begin
      exp_line.delete();
      exp_rd = 1'b0; exp_txd = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
    end else if (exp_line.size() == 0) begin
      exp_rd = bus.tx_en && (model_q.size() > 0);
      exp_txd = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      if (exp_rd) build_frame(model_q.pop_front());
    end else begin
      exp_txd  = exp_line.pop_front();
      exp_busy = 1'b1;
      exp_rd   = 1'b0;
      exp_done = (exp_line.size() == 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.tx_en = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_rd_data = 8'h00;
    tick(); tick();
    checks++;
    if ({bus.txd, bus.busy, bus.byte_done} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_idle txd/busy/done got %b%b%b expected 100", bus.txd, bus.busy, bus.byte_done);
    end
    push_byte(8'hA5);
    bus.tx_en = 1'b1;
    #1;
    checks++;
    if (bus.fifo_rd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rd_forced got %b expected 0", bus.fifo_rd);
    end
    tick();
    checks++;
    if (fifo_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL reset_no_pop fifo level got %0d expected 1", fifo_q.size());
    end
    bus.tx_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_a5();
    logic [9:0] pat;
    int rd_cnt, done_cnt, pat_len;
    pat = 10'b1101001010;
    pat_len = (PAR != 0) ? 9 : 10;
    rd_cnt = 0; done_cnt = 0;
    bus.tx_en = 1'b1;
    for (int c = 0; c < 2 + FRAME + 4; c++) begin
      #1;
      model_step();
      txd_log[c] = bus.txd;
      rd_cnt += int'(bus.fifo_rd);
      done_cnt += int'(bus.byte_done);
      checks++;
      if ({bus.txd, bus.fifo_rd, bus.busy, bus.byte_done} !== {exp_txd, exp_rd, exp_busy, exp_done}) begin
        errors++;
        $display("[TB] FAIL a5_frame cyc %0d txd/rd/busy/done got %b%b%b%b expected %b%b%b%b",
                 c, bus.txd, bus.fifo_rd, bus.busy, bus.byte_done, exp_txd, exp_rd, exp_busy, exp_done);
      end
      tick();
    end
    for (int k = 0; k < pat_len; k++) begin
      checks++;
      if (txd_log[2 + k * CPB + 1] !== pat[k]) begin
        errors++;
        $display("[TB] FAIL a5_bit%0d got %b expected %b", k, txd_log[2 + k * CPB + 1], pat[k]);
      end
    end
    checks++;
    if (rd_cnt != 1 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL a5_pulses rd/done got %0d/%0d expected 1/1", rd_cnt, done_cnt);
    end
  endtask

  task automatic test_empty();
    int rd_cnt;
    rd_cnt = 0;
    bus.tx_en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      model_step();
      rd_cnt += int'(bus.fifo_rd);
      checks++;
      if ({bus.txd, bus.fifo_rd, bus.busy, bus.byte_done} !== {exp_txd, exp_rd, exp_busy, exp_done}) begin
        errors++;
        $display("[TB] FAIL empty_idle cyc %0d txd/rd/busy/done got %b%b%b%b expected %b%b%b%b",
                 c, bus.txd, bus.fifo_rd, bus.busy, bus.byte_done, exp_txd, exp_rd, exp_busy, exp_done);
      end
      tick();
    end
    checks++;
    if (rd_cnt != 0) begin
      errors++;
      $display("[TB] FAIL empty_no_pop got %0d pops expected 0", rd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n, first_done, gap;
    n = 2 * (FRAME + 2) + 4;
    push_byte(8'h00);
    push_byte(8'hFF);
    bus.tx_en = 1'b1;
    first_done = -1;
    for (int c = 0; c < n; c++) begin
      #1;
      model_step();
      txd_log[c] = bus.txd;
      done_log[c] = bus.byte_done;
      if (first_done < 0 && bus.byte_done === 1'b1) first_done = c;
      checks++;
      if ({bus.txd, bus.fifo_rd, bus.busy, bus.byte_done} !== {exp_txd, exp_rd, exp_busy, exp_done}) begin
        errors++;
        $display("[TB] FAIL b2b_frame cyc %0d txd/rd/busy/done got %b%b%b%b expected %b%b%b%b",
                 c, bus.txd, bus.fifo_rd, bus.busy, bus.byte_done, exp_txd, exp_rd, exp_busy, exp_done);
      end
      tick();
    end
    gap = 0;
    if (first_done >= 0) begin
      for (int j = first_done + 1; j < n && txd_log[j] === 1'b1; j++) gap++;
    end
    checks++;
    if (gap != 2) begin
      errors++;
      $display("[TB] FAIL b2b_gap got %0d high cycles expected 2", gap);
    end
    checks++;
    if (fifo_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain fifo level got %0d expected 0", fifo_q.size());
    end
  endtask

  task automatic test_tx_en_drop();
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    bus.tx_en = 1'b1;
    for (int c = 0; c < 2 + FRAME + 12; c++) begin
      if (c == 2 + 4 * CPB + 1) bus.tx_en = 1'b0;
      #1;
      model_step();
      checks++;
      if ({bus.txd, bus.fifo_rd, bus.busy, bus.byte_done} !== {exp_txd, exp_rd, exp_busy, exp_done}) begin
        errors++;
        $display("[TB] FAIL en_drop cyc %0d txd/rd/busy/done got %b%b%b%b expected %b%b%b%b",
                 c, bus.txd, bus.fifo_rd, bus.busy, bus.byte_done, exp_txd, exp_rd, exp_busy, exp_done);
      end
      tick();
    end
    checks++;
    if (fifo_q.size() != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_drop_end fifo level/busy got %0d/%b expected 1/0", fifo_q.size(), bus.busy);
    end
    fifo_q.delete();
    model_q.delete();
    bus.fifo_empty = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int pops_before, rst_cyc;
    pops_before = pop_total;
    rst_cyc = 2 + 6 * CPB + 1;
    push_byte(8'($urandom));
    bus.tx_en = 1'b1;
    for (int c = 0; c < 2 * FRAME + 20; c++) begin
      rst = (c == rst_cyc);
      if (c == rst_cyc + 6) push_byte(8'($urandom));
      #1;
      model_step();
      if (rst) begin
        checks++;
        if (bus.fifo_rd !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rst_mid_rd got %b expected 0", bus.fifo_rd);
        end
      end else begin
        checks++;
        if ({bus.txd, bus.fifo_rd, bus.busy, bus.byte_done} !== {exp_txd, exp_rd, exp_busy, exp_done}) begin
          errors++;
          $display("[TB] FAIL rst_mid cyc %0d txd/rd/busy/done got %b%b%b%b expected %b%b%b%b",
                   c, bus.txd, bus.fifo_rd, bus.busy, bus.byte_done, exp_txd, exp_rd, exp_busy, exp_done);
        end
      end
      tick();
    end
    rst = 1'b0;
    checks++;
    if (pop_total - pops_before != 2) begin
      errors++;
      $display("[TB] FAIL rst_mid_pops got %0d expected 2", pop_total - pops_before);
    end
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    c = 0;
    while ((model_q.size() > 0 || exp_line.size() > 0) && c < 3000) begin
      bus.tx_en = ($urandom_range(0, 3) != 0);
      #1;
      model_step();
      checks++;
      if ({bus.txd, bus.fifo_rd, bus.busy, bus.byte_done} !== {exp_txd, exp_rd, exp_busy, exp_done}) begin
        errors++;
        $display("[TB] FAIL random cyc %0d txd/rd/busy/done got %b%b%b%b expected %b%b%b%b",
                 c, bus.txd, bus.fifo_rd, bus.busy, bus.byte_done, exp_txd, exp_rd, exp_busy, exp_done);
      end
      tick();
      c++;
    end
    checks++;
    if (model_q.size() != 0 || fifo_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_drain model/fifo level got %0d/%0d expected 0/0", model_q.size(), fifo_q.size());
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    int last;
    push_byte(8'h07);
    bus.tx_en = 1'b1;
    for (int c = 0; c < 2 + FRAME + 4; c++) begin
      #1;
      model_step();
      txd_log[c] = bus.txd;
      done_log[c] = bus.byte_done;
      checks++;
      if ({bus.txd, bus.fifo_rd, bus.busy, bus.byte_done} !== {exp_txd, exp_rd, exp_busy, exp_done}) begin
        errors++;
        $display("[TB] FAIL parity_frame cyc %0d txd/rd/busy/done got %b%b%b%b expected %b%b%b%b",
                 c, bus.txd, bus.fifo_rd, bus.busy, bus.byte_done, exp_txd, exp_rd, exp_busy, exp_done);
      end
      tick();
    end
    checks++;
    if (txd_log[2 + 9 * CPB + 1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL parity_bit got %b expected 1", txd_log[2 + 9 * CPB + 1]);
    end
    last = 2 + 12 * CPB - 1;
    for (int j = 2 + 10 * CPB; j <= last; j++) begin
      checks++;
      if (txd_log[j] !== 1'b1 || done_log[j] !== (j == last)) begin
        errors++;
        $display("[TB] FAIL parity_stop cyc %0d txd/done got %b%b expected 1%b", j, txd_log[j], done_log[j], (j == last));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_a5();
    test_empty();
    test_back_to_back();
    test_tx_en_drop();
    test_reset_mid_frame();
    test_random();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
